// File: rtl/sum_uart_tx.sv
// sum_uart_tx: serialises 8-bit sums from the adder stage onto one UART pin.
//
// Accepted words are buffered in a small circular FIFO and transmitted as
// 8N1 frames (start bit, 8 data bits LSB first, stop bit). Back-to-back
// frames follow each other with no idle gap while the FIFO holds data.
//
// Optional build macro SUM_UART_TX_PARITY_EN: when defined, an even-parity
// bit is inserted between the last data bit and the stop bit (8E1 framing,
// 11 bit times per frame). When undefined, frames are plain 8N1.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ena       design enable; 0 freezes all state
//   in_data   sum from the adder stage
//   in_valid  in_data is valid this cycle
//   in_ready  block can accept in_data this cycle (FIFO not full)
//   tx        UART serial output, idles high
//   busy      frame in progress or FIFO not empty
//   overflow  sticky: a word was offered while the FIFO was full
module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMAX  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);

`ifdef SUM_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // Transmitter state
    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_end;
`ifdef SUM_UART_TX_PARITY_EN
    logic          par_bit;
`endif

    assign fifo_full  = (count == CFULL);
    assign fifo_empty = (count == '0);
    assign bit_end    = (timer == '0);

    // Handshake and status depend only on flops, never on in_valid.
    assign in_ready = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;

    assign push = ena && in_valid && !fifo_full;
    // The head is taken either from IDLE or at the last cycle of a stop bit,
    // which is what lets consecutive frames abut with no idle gap.
    assign pop  = ena && !fifo_empty &&
                  ((state == IDLE) || ((state == STOP) && bit_end));

    // FIFO data array: payload only, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ena && in_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame sequencer; tx is registered here so the pin never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
`ifdef SUM_UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
`ifdef SUM_UART_TX_PARITY_EN
                        par_bit <= ^mem[rd_ptr];
`endif
                        timer   <= TMAX;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        timer   <= TMAX;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        timer <= TMAX;
                        if (bit_idx == 3'd7) begin
`ifdef SUM_UART_TX_PARITY_EN
                            tx    <= par_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            // Next bit is shift[1] before the shift lands
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

`ifdef SUM_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        timer <= TMAX;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift   <= mem[rd_ptr];
`ifdef SUM_UART_TX_PARITY_EN
                            par_bit <= ^mem[rd_ptr];
`endif
                            timer   <= TMAX;
                            bit_idx <= '0;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sum_uart_tx.md
Name: sum_uart_tx

Overview:
- Downstream stage of the 8-bit adder top. It consumes each 8-bit sum produced by the adder over a valid/ready handshake.
- Sums are buffered in a small FIFO and serialised onto one output pin as 8N1 UART frames, LSB first.
- It lets the chip stream results off a single uo_out bit instead of using all eight outputs.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be >= 2.
- FIFO_DEPTH, 4, number of FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; 0 freezes all state
- in_data  input  8  sum from the adder stage
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept in_data this cycle
- tx  output  1  UART serial output, idles high
- busy  output  1  frame in progress or FIFO not empty
- overflow  output  1  sticky: a word was offered while the FIFO was full

Behaviour:
- Reset is asynchronous on rst_n low. All state is cleared:
  - tx=1, busy=0, overflow=0, in_ready=1
  - FIFO empty, FSM in IDLE, bit timer=0, bit index=0
- in_ready = !fifo_full, derived from registered count only. It has no combinational path from in_valid.
- Push: on the rising edge where ena && in_valid && in_ready, in_data is written to the FIFO.
- Offer while full: if in_valid && !in_ready && ena at an edge, the word is dropped and overflow is set. overflow stays at 1 until reset.
- ena=0: no push, no pop, timer and FSM hold, tx holds its current level.
- FIFO: circular buffer with wrapping read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop on an empty FIFO never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is not empty, pop the head into an 8-bit shift register, load timer=CLKS_PER_BIT-1 and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift[0], one bit per CLKS_PER_BIT cycles, bit index 0..7. Shift right at the end of each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Timer: counts down to 0; each state or bit ends on the cycle where timer==0, then reloads CLKS_PER_BIT-1.
- Latency:
  - A word accepted at edge N into an empty, idle block drives tx low after edge N+1.
  - A frame lasts exactly 10*CLKS_PER_BIT cycles.
- tx is a registered output with no glitches.
- busy = (state != IDLE) || !fifo_empty, registered-equivalent (derived only from flops).
- Simultaneous push into an empty FIFO while in IDLE: the word is written at edge N and popped at edge N+1. It never bypasses the FIFO.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The partial frame is abandoned and FIFO contents are discarded.

Optional Feature:
- Macro: SUM_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - A frame is 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state exists; the frame is 8N1 at 10*CLKS_PER_BIT cycles.

Test Plan:
- CLKS_PER_BIT=4. Reset, then push 8'hA5 once -> tx low at edge N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; busy drops after 40 cycles.
- Push 8'h00 then 8'hFF on consecutive cycles -> two frames back-to-back with no idle cycle between the 1st STOP and the 2nd START; total 80 cycles.
- FIFO_DEPTH=4, block idle and tx stalled via ena sequencing. Push 5 words while the first frame is in progress -> in_ready=0 once 4 words are queued, 5th word dropped, overflow=1. Exactly 5 frames: the word in progress plus the 4 queued.
- Assert rst_n low mid-DATA of frame 8'h3C -> tx=1, busy=0, overflow=0, in_ready=1 immediately; no further frames after release.
- Hold ena=0 for 7 cycles mid-STOP -> tx held high, frame resumes and total frame length extends by exactly 7 cycles.
- With SUM_UART_TX_PARITY_EN, push 8'h07 -> parity bit 1 after data, frame 44 cycles. Push 8'h03 -> parity bit 0.
